// File: rtl/tnn_vote_accumulator.sv
// Serial vote accumulator: counts per-class neuron votes and reports the winning class and score per sample.
// Optional feature: define TNN_VOTE_MARGIN_EN to track the second-best count and emit out_margin.
module tnn_vote_accumulator #(
    parameter int NUM_CLASSES = 7,
    parameter int VOTES       = 15,
    parameter int CLS_W       = 3,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CLS_W-1:0] out_class,
    output logic [CNT_W-1:0] out_score,
    output logic             err
`ifdef TNN_VOTE_MARGIN_EN
    ,
    output logic [CNT_W-1:0] out_margin
`endif
);

    localparam int VID_W = (VOTES > 1) ? $clog2(VOTES) : 1;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [VID_W-1:0]   vote_idx_q, vote_idx_d;
    logic [CLS_W-1:0]   class_idx_q, class_idx_d;
    logic [CNT_W-1:0]   cur_cnt_q, cur_cnt_d;
    logic [CNT_W-1:0]   best_cnt_q, best_cnt_d;
    logic [CLS_W-1:0]   best_cls_q, best_cls_d;
    logic [CLS_W-1:0]   out_class_q, out_class_d;
    logic [CNT_W-1:0]   out_score_q, out_score_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               err_q, err_d;

    logic [CNT_W-1:0]   done_cnt_s;
    logic               last_vote_s;
    logic               final_s;
    logic               take_s;
    logic [CNT_W-1:0]   nxt_best_cnt_s;
    logic [CLS_W-1:0]   nxt_best_cls_s;

`ifdef TNN_VOTE_MARGIN_EN
    logic [CNT_W-1:0]   second_cnt_q, second_cnt_d;
    logic [CNT_W-1:0]   out_margin_q, out_margin_d;
    logic [CNT_W-1:0]   nxt_second_s;
`endif

    // Per-beat datapath: completed class count and the best tracking it would produce.
    always_comb begin
        done_cnt_s  = cur_cnt_q + {{(CNT_W-1){1'b0}}, in_bit};
        last_vote_s = (vote_idx_q == VID_W'(VOTES - 1));
        final_s     = last_vote_s && (class_idx_q == CLS_W'(NUM_CLASSES - 1));
        // Class 0 always seeds the best; later classes need a strict win so ties keep the lower index.
        take_s      = (class_idx_q == {CLS_W{1'b0}}) || (done_cnt_s > best_cnt_q);
        if (take_s) begin
            nxt_best_cnt_s = done_cnt_s;
            nxt_best_cls_s = class_idx_q;
        end else begin
            nxt_best_cnt_s = best_cnt_q;
            nxt_best_cls_s = best_cls_q;
        end
`ifdef TNN_VOTE_MARGIN_EN
        if (class_idx_q == {CLS_W{1'b0}}) begin
            nxt_second_s = {CNT_W{1'b0}};
        end else if (take_s) begin
            nxt_second_s = best_cnt_q;
        end else if (done_cnt_s > second_cnt_q) begin
            nxt_second_s = done_cnt_s;
        end else begin
            nxt_second_s = second_cnt_q;
        end
`endif
    end

    // Next-state and register-input logic for the INIT/ACC/OUT controller.
    always_comb begin
        state_d     = state_q;
        vote_idx_d  = vote_idx_q;
        class_idx_d = class_idx_q;
        cur_cnt_d   = cur_cnt_q;
        best_cnt_d  = best_cnt_q;
        best_cls_d  = best_cls_q;
        out_class_d = out_class_q;
        out_score_d = out_score_q;
        err_d       = err_q;
`ifdef TNN_VOTE_MARGIN_EN
        second_cnt_d = second_cnt_q;
        out_margin_d = out_margin_q;
`endif
        case (state_q)
            ST_INIT: begin
                state_d = ST_ACC;
            end
            ST_ACC: begin
                if (in_valid && in_ready_q) begin
                    if (in_last && !final_s) begin
                        // Framing error: drop the partial sample and stay collecting.
                        vote_idx_d  = {VID_W{1'b0}};
                        class_idx_d = {CLS_W{1'b0}};
                        cur_cnt_d   = {CNT_W{1'b0}};
                        best_cnt_d  = {CNT_W{1'b0}};
                        best_cls_d  = {CLS_W{1'b0}};
`ifdef TNN_VOTE_MARGIN_EN
                        second_cnt_d = {CNT_W{1'b0}};
`endif
                        err_d       = 1'b1;
                    end else if (final_s) begin
                        out_class_d = nxt_best_cls_s;
                        out_score_d = nxt_best_cnt_s;
`ifdef TNN_VOTE_MARGIN_EN
                        out_margin_d = nxt_best_cnt_s - nxt_second_s;
                        second_cnt_d = {CNT_W{1'b0}};
`endif
                        vote_idx_d  = {VID_W{1'b0}};
                        class_idx_d = {CLS_W{1'b0}};
                        cur_cnt_d   = {CNT_W{1'b0}};
                        best_cnt_d  = {CNT_W{1'b0}};
                        best_cls_d  = {CLS_W{1'b0}};
                        err_d       = err_q | ~in_last;
                        state_d     = ST_OUT;
                    end else if (last_vote_s) begin
                        best_cnt_d  = nxt_best_cnt_s;
                        best_cls_d  = nxt_best_cls_s;
`ifdef TNN_VOTE_MARGIN_EN
                        second_cnt_d = nxt_second_s;
`endif
                        vote_idx_d  = {VID_W{1'b0}};
                        cur_cnt_d   = {CNT_W{1'b0}};
                        class_idx_d = class_idx_q + {{(CLS_W-1){1'b0}}, 1'b1};
                    end else begin
                        cur_cnt_d   = done_cnt_s;
                        vote_idx_d  = vote_idx_q + {{(VID_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_ACC;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
        in_ready_d  = (state_d == ST_ACC);
        out_valid_d = (state_d == ST_OUT);
    end

    // State and output registers; reset discards any partial sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            vote_idx_q  <= {VID_W{1'b0}};
            class_idx_q <= {CLS_W{1'b0}};
            cur_cnt_q   <= {CNT_W{1'b0}};
            best_cnt_q  <= {CNT_W{1'b0}};
            best_cls_q  <= {CLS_W{1'b0}};
            out_class_q <= {CLS_W{1'b0}};
            out_score_q <= {CNT_W{1'b0}};
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
`ifdef TNN_VOTE_MARGIN_EN
            second_cnt_q <= {CNT_W{1'b0}};
            out_margin_q <= {CNT_W{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            vote_idx_q  <= vote_idx_d;
            class_idx_q <= class_idx_d;
            cur_cnt_q   <= cur_cnt_d;
            best_cnt_q  <= best_cnt_d;
            best_cls_q  <= best_cls_d;
            out_class_q <= out_class_d;
            out_score_q <= out_score_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
`ifdef TNN_VOTE_MARGIN_EN
            second_cnt_q <= second_cnt_d;
            out_margin_q <= out_margin_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_class = out_class_q;
    assign out_score = out_score_q;
    assign err       = err_q;
`ifdef TNN_VOTE_MARGIN_EN
    assign out_margin = out_margin_q;
`endif

endmodule

// File: tb/tb_tnn_vote_accumulator.sv
// Scoreboard bench for tnn_vote_accumulator: random and directed samples against a count-level reference model.
// Build with TNN_VOTE_MARGIN_EN defined to also check out_margin.
module tb_tnn_vote_accumulator;

    localparam int NC = 7;
    localparam int V  = 15;
    localparam int CW = 3;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_bit = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b1;
    logic          in_ready;
    logic          out_valid;
    logic [CW-1:0] out_class;
    logic [NW-1:0] out_score;
    logic          err;
`ifdef TNN_VOTE_MARGIN_EN
    logic [NW-1:0] out_margin;
`endif

    tnn_vote_accumulator #(.NUM_CLASSES(NC), .VOTES(V), .CLS_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_score(out_score), .err(err)
`ifdef TNN_VOTE_MARGIN_EN
        , .out_margin(out_margin)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int cls;
        int score;
        int err;
        int margin;
    } exp_t;
    typedef int cnt_t [NC];

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    bit   model_err = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: winner is the first class holding the maximum count; margin against the next largest count.
    function automatic exp_t ref_model(input cnt_t cnt, input bit last_ok);
        exp_t e;
        int best = 0;
        int second = 0;
        for (int c = 1; c < NC; c++) if (cnt[c] > cnt[best]) best = c;
        for (int c = 0; c < NC; c++) if (c != best && cnt[c] > second) second = cnt[c];
        e.cls    = best;
        e.score  = cnt[best];
        e.margin = cnt[best] - second;
        e.err    = (model_err || !last_ok) ? 1 : 0;
        return e;
    endfunction

    // Monitor: every result handshake is popped and compared against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("out_class", int'(out_class), mon_e.cls);
                check("out_score", int'(out_score), mon_e.score);
                check("out_err", int'(err), mon_e.err);
`ifdef TNN_VOTE_MARGIN_EN
                check("out_margin", int'(out_margin), mon_e.margin);
`endif
            end
        end
    end

    task automatic drive_beat(input bit b, input bit l);
        bit ok = 1'b0;
        if ($urandom_range(3, 0) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_bit   = b;
        in_last  = l;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("beat_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_sample(input cnt_t cnt, input bit with_last, input int early_at, input int abort_at);
        int n = 0;
        exp_t e;
        for (int c = 0; c < NC; c++) begin
            int ones = cnt[c];
            for (int v = 0; v < V; v++) begin
                bit b;
                b = ($urandom_range(V - v - 1, 0) < ones);
                if (b) ones--;
                n++;
                if (n == early_at) begin
                    drive_beat(b, 1'b1);
                    model_err = 1'b1;
                    return;
                end
                if (n == NC * V) begin
                    e = ref_model(cnt, with_last);
                    sb_q.push_back(e);
                    model_err = (e.err != 0);
                    drive_beat(b, with_last);
                    check("latency_out_valid", int'(out_valid), 1);
                end else begin
                    drive_beat(b, 1'b0);
                end
                if (n == abort_at) return;
            end
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 50; k++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk); #1;
        end
        if (sb_q.size() != 0) begin
            check("drain_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release_0", int'(in_ready), 0);
        @(negedge clk);
        check("ready_after_release_1", int'(in_ready), 1);
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, int'(in_ready), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_class"}, int'(out_class), 0);
        check({tag, "_out_score"}, int'(out_score), 0);
        check({tag, "_err"}, int'(err), 0);
`ifdef TNN_VOTE_MARGIN_EN
        check({tag, "_out_margin"}, int'(out_margin), 0);
`endif
    endtask

    cnt_t cnt;

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        release_reset();

        // Clear winner: class 4 with 12, everyone else 3.
        for (int c = 0; c < NC; c++) cnt[c] = 3;
        cnt[4] = 12;
        send_sample(cnt, 1'b1, 0, 0);
        wait_drain();

        // Tie between classes 2 and 5 keeps the lower index.
        for (int c = 0; c < NC; c++) cnt[c] = 4;
        cnt[2] = 9;
        cnt[5] = 9;
        send_sample(cnt, 1'b1, 0, 0);
        wait_drain();

        // Backpressure: result held with in_valid asserted and out_ready low.
        for (int c = 0; c < NC; c++) cnt[c] = 5;
        cnt[1] = 13;
        out_ready = 1'b0;
        send_sample(cnt, 1'b1, 0, 0);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_class", int'(out_class), 1);
            check("bp_out_score", int'(out_score), 13);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        check("bp_popped", sb_q.size(), 0);
        @(negedge clk);
        check("bp_ready_after", int'(in_ready), 1);
        @(posedge clk); #1;

        // Early in_last on beat 20, then a full sample that still reports err.
        for (int c = 0; c < NC; c++) cnt[c] = int'($urandom_range(V, 0));
        send_sample(cnt, 1'b1, 20, 0);
        repeat (3) @(posedge clk);
        #1;
        check("early_err", int'(err), 1);
        check("early_no_output", int'(out_valid), 0);
        for (int c = 0; c < NC; c++) cnt[c] = int'($urandom_range(V, 0));
        send_sample(cnt, 1'b1, 0, 0);
        wait_drain();

        // Reset in the middle of a sample at beat 50.
        for (int c = 0; c < NC; c++) cnt[c] = int'($urandom_range(V, 0));
        send_sample(cnt, 1'b1, 0, 50);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        sb_q.delete();
        model_err = 1'b0;
        release_reset();
        for (int c = 0; c < NC; c++) cnt[c] = 2;
        cnt[6] = 11;
        send_sample(cnt, 1'b1, 0, 0);
        wait_drain();

        // Random samples; ties forced sometimes, missing in_last on the last few.
        for (int s = 0; s < 12; s++) begin
            for (int c = 0; c < NC; c++) cnt[c] = int'($urandom_range(V, 0));
            if ($urandom_range(2, 0) == 0) cnt[$urandom_range(NC - 1, 0)] = cnt[$urandom_range(NC - 1, 0)];
            send_sample(cnt, (s < 9), 0, 0);
            wait_drain();
        end

        repeat (4) @(posedge clk);
        check("final_queue_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tnn_vote_accumulator.md
# tnn_vote_accumulator

Sequential vote-collection stage directly downstream of the approximate TNN comparator neurons.
- Consumes the neurons' 1-bit outputs as a serial valid/ready stream, one vote per beat, grouped class-major.
- Counts the votes per output class and tracks the running best class.
- Emits the winning class index and its vote count once per sample.
- Feeds the classifier result register / host readout.

## Interface
Parameters:
- NUM_CLASSES, 7: number of output classes (wine quality bins).
- VOTES, 15: votes (neuron bits) per class per sample.
- CLS_W, 3: width of the class index; requires 2^CLS_W >= NUM_CLASSES.
- CNT_W, 4: width of a vote count; requires 2^CNT_W > VOTES.

Ports:
- clk, input, 1: sole clock; all state updates on the rising edge.
- rst_n, input, 1: reset; asynchronous assert, active-low.
- in_valid, input, 1: vote beat valid.
- in_ready, output, 1: block accepts a vote beat.
- in_bit, input, 1: neuron output; 1 = vote for the current class.
- in_last, input, 1: marks the final beat of a sample.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts the result.
- out_class, output, CLS_W: winning class index.
- out_score, output, CNT_W: vote count of the winning class.
- err, output, 1: sticky framing-error flag.
- out_margin, output, CNT_W: best count minus second-best count. Present only with TNN_VOTE_MARGIN_EN.

## Operation
- FSM states: INIT, ACC, OUT. Reset enters INIT.
  - INIT -> ACC unconditionally on the next clock.
- Beat transfer: a beat transfers when in_valid && in_ready. in_ready = 1 only in ACC.
- Counters: vote_idx (0..VOTES-1), class_idx (0..NUM_CLASSES-1), cur_cnt (CNT_W).
  - Each transfer: cur_cnt += in_bit, then vote_idx increments.
  - When vote_idx = VOTES-1: the completed count (cur_cnt + in_bit) is compared against best_cnt. Then cur_cnt clears, vote_idx clears, and class_idx increments.
- Best-class update: strictly greater replaces best_cnt/best_cls, so ties keep the lower class index. Class 0 always initialises best_cnt/best_cls.
- Final beat (class_idx = NUM_CLASSES-1, vote_idx = VOTES-1) moves the FSM ACC -> OUT.
  - out_class/out_score are loaded from the final best values.
  - All counters clear.
- Output handshake: in OUT, outputs are held stable until out_ready. On out_valid && out_ready the FSM goes OUT -> ACC.
- Count width: counts never exceed VOTES, so no saturation logic is required.
- Early in_last (in_last on any beat other than the final beat):
  - The beat is accepted.
  - All counters and the best tracking clear; no result is emitted.
  - err is set; the FSM stays in ACC.
- Missing in_last (final beat without in_last): the result is emitted normally and err is set.
- err clears only on reset.

## Timing
- Reset values:
  - in_ready = 0, out_valid = 0, out_class = 0, out_score = 0, err = 0, out_margin = 0.
  - FSM = INIT; all counters = 0.
- First clock after rst_n deasserts: INIT -> ACC; in_ready = 1 from the following cycle.
- Latency: the final beat transfers at edge t, and out_valid = 1 in the cycle after edge t.
- Sample length: NUM_CLASSES*VOTES beats, i.e. 105 by default.
- Back-to-back: the output transfers at edge u; in_ready = 1 in the cycle after edge u.
  - Minimum spacing per sample: 105 beats + 1 output cycle.
- in_valid while in OUT: not accepted, and in_bit is ignored.
- Reset mid-operation: all state is discarded immediately (asynchronous). Any partial sample is lost and no output is produced.

## Configuration
- TNN_VOTE_MARGIN_EN defined:
  - A second-best count register is tracked alongside the best. It updates when a completed count is <= best but > second-best, or when it displaces the old best.
  - out_margin = best - second at the OUT load; it is held with out_class.
- TNN_VOTE_MARGIN_EN undefined: the out_margin port and the second-best logic are absent. All other behaviour is identical.

## Test plan
- Reset:
  - Assert rst_n=0 mid-cycle -> all outputs 0 immediately.
  - Release -> in_ready=0 for 1 cycle, then in_ready=1.
- Clear winner:
  - Stimulus: class 4 gets 12 ones; classes 0-3 and 5-6 get 3 ones each; in_last on beat 105.
  - Response: out_valid=1 next cycle, out_class=4, out_score=12, err=0. With the macro, out_margin=9.
- Tie:
  - Stimulus: classes 2 and 5 get 9 ones each; all others get 4.
  - Response: out_class=2, out_score=9. With the macro, out_margin=0.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles after the result while in_valid=1.
  - Response: outputs stable and in_ready=0 throughout. out_ready=1 -> transfer, then in_ready=1 the next cycle.
- Early in_last:
  - Stimulus: in_last on beat 20.
  - Response: no out_valid and err=1. The next full 105-beat sample gives a correct result, with err still 1.
- Reset mid-sample:
  - Stimulus: rst_n pulse at beat 50.
  - Response: no output from that sample. The next full sample gives the correct class, with err=0.
